// File: rtl/btb_update.sv
// Branch target buffer update path: filters resolved branches, queues table
// writes in a small coalescing FIFO, and sweeps the table clear after reset or flush.
module btb_update (
  input  logic        CLK,
  input  logic        RST,
  input  logic        upd_valid,
  input  logic [12:0] upd_pc,
  input  logic [12:0] upd_target,
  input  logic        upd_taken,
  input  logic        upd_hit,
  input  logic        flush_req,
  output logic [10:0] w_addr,
  output logic [15:0] w_data,
  output logic        wen,
  output logic        busy,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned IDX_W   = 11;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned PTR_W   = 2;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned DROP_W  = 8;

  typedef enum logic {
    SWEEP = 1'b0,
    IDLE  = 1'b1
  } state_t;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   sweep_cnt;
  fifo_entry_t        fifo [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   tail_ptr;
  logic [CNT_W-1:0]   count;

  logic               cand;
  logic [IDX_W-1:0]   cand_idx;
  logic [DATA_W-1:0]  cand_data;
  logic               idle_run;
  logic               pop;
  logic               coalesce;
  logic               fwd;
  logic               push;
  logic               drop;

  // Candidate filtering, entry encoding and FIFO control decisions
  always_comb begin
    cand      = upd_valid & (upd_taken | upd_hit);
    cand_idx  = upd_pc[10:0];
    cand_data = upd_taken ? {1'b1, upd_pc[12:11], upd_target} : 16'h0000;
    tail_ptr  = wr_ptr - 2'd1;
    idle_run  = (state == IDLE) && !flush_req;
    pop       = idle_run && (count != 3'd0);
    coalesce  = idle_run && cand && (count != 3'd0) && (fifo[tail_ptr].idx == cand_idx);
    // A single queued entry is also the head being drained: forward the new data
    fwd       = coalesce && (count == 3'd1);
    push      = idle_run && cand && !coalesce && ((count != CNT_W'(DEPTH)) || pop);
    drop      = idle_run && cand && !coalesce && (count == CNT_W'(DEPTH)) && !pop;
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= SWEEP;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      SWEEP:   if (!flush_req && (sweep_cnt == 11'd2047)) state_nxt = IDLE;
      IDLE:    if (flush_req) state_nxt = SWEEP;
      default: state_nxt = SWEEP;
    endcase
  end

  assign busy = (state == SWEEP);

  // Sweep index: advances during SWEEP, restarts on any flush
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                   sweep_cnt <= '0;
    else if (flush_req)        sweep_cnt <= '0;
    else if (state == SWEEP)   sweep_cnt <= sweep_cnt + 11'd1;
  end

  // Table write port: sweep clears win over FIFO drain
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wen    <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
    end else if (state == SWEEP) begin
      wen    <= 1'b1;
      w_addr <= sweep_cnt;
      w_data <= '0;
    end else if (pop) begin
      wen    <= 1'b1;
      w_addr <= fifo[rd_ptr].idx;
      w_data <= fwd ? cand_data : fifo[rd_ptr].data;
    end else begin
      wen    <= 1'b0;
    end
  end

  // FIFO pointers and occupancy; flush in IDLE discards pending entries
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if ((state == IDLE) && flush_req) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // FIFO storage: in-place coalesce or append
  always_ff @(posedge CLK) begin
    if (coalesce && !fwd) fifo[tail_ptr].data <= cand_data;
    if (push)             fifo[wr_ptr] <= '{idx: cand_idx, data: cand_data};
  end

  // Saturating count of candidates lost to a full FIFO
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                             drop_cnt <= '0;
    else if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + DROP_W'(1);
  end

endmodule
